// File: rtl/sequence_generator.sv
// Serial pattern transmitter: sends the low `length` bits of a captured pattern
// MSB-first, repeated back-to-back with a one-cycle idle gap between repetitions.
module sequence_generator #(
    parameter int MAX_LEN = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [3:0]         length,
    input  logic [3:0]         repeat_count,
    output logic               data_out,
    output logic               data_valid,
    output logic               busy,
    output logic               done,
    output logic [1:0]         state_dbg
);

    // Request semantics: start is a level request sampled only on an edge where
    // the FSM is IDLE and length is legal; from the accepting edge until the edge
    // after DONE, busy=1 and start/pattern/length/repeat_count are ignored.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [4:0] LEN_MAX = 5'(MAX_LEN);

    state_t             r_state;
    state_t             w_next;
    logic [MAX_LEN-1:0] r_pattern;
    logic [MAX_LEN-1:0] r_shift;
    logic [3:0]         r_len;
    logic [3:0]         r_bit;
    logic [3:0]         r_rep;

    logic               w_len_ok;
    logic               w_accept;
    logic               w_last_bit;
    logic [MAX_LEN-1:0] w_aligned;

    assign w_len_ok   = (length != 4'd0) && ({1'b0, length} <= LEN_MAX);
    assign w_accept   = (r_state == IDLE) && start && w_len_ok;
    assign w_last_bit = (r_bit == 4'd0);
    // Left-align the pattern so the next bit to send is always the top bit.
    assign w_aligned  = pattern << (LEN_MAX - {1'b0, length});

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = SHIFT;
                end
            end
            SHIFT: begin
                if (w_last_bit) begin
                    w_next = (r_rep > 4'd1) ? GAP : DONE;
                end
            end
            GAP:     w_next = SHIFT;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pattern <= '0;
            r_shift   <= '0;
            r_len     <= 4'd0;
            r_bit     <= 4'd0;
            r_rep     <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_pattern <= w_aligned;
                        r_shift   <= w_aligned;
                        r_len     <= length;
                        r_bit     <= length - 4'd1;
                        r_rep     <= (repeat_count == 4'd0) ? 4'd1 : repeat_count;
                    end
                end
                SHIFT: begin
                    if (!w_last_bit) begin
                        r_shift <= r_shift << 1;
                        r_bit   <= r_bit - 4'd1;
                    end
                end
                GAP: begin
                    r_shift <= r_pattern;
                    r_bit   <= r_len - 4'd1;
                    r_rep   <= r_rep - 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign data_valid = (r_state == SHIFT);
    assign data_out   = data_valid & r_shift[MAX_LEN-1];
    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);
    assign state_dbg  = r_state;

endmodule

// File: tb/tb_sequence_generator.sv
// Bench for sequence_generator: per-cycle comparison against a queue-based
// model of the emitted stream, plus literal checks on captured streams and counts.
module tb_sequence_generator;

    localparam int MAX_LEN = 8;

    logic               clock = 1'b0;
    logic               reset;
    logic               start;
    logic [MAX_LEN-1:0] pattern;
    logic [3:0]         length;
    logic [3:0]         repeat_count;
    logic               data_out;
    logic               data_valid;
    logic               busy;
    logic               done;
    logic [1:0]         state_dbg;

    sequence_generator #(.MAX_LEN(MAX_LEN)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .pattern      (pattern),
        .length       (length),
        .repeat_count (repeat_count),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .busy         (busy),
        .done         (done),
        .state_dbg    (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- bookkeeping ----------------
    int tests_run    = 0;
    int tests_failed = 0;

    // expected {data_valid, data_out, busy, done} per cycle
    logic [3:0] exp_q[$];
    logic       model_busy = 1'b0;

    logic [63:0] cap;
    int          cap_n;
    int          busy_n;
    int          done_n;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s @%0t: got %0h, required %0h", name, $time, act, req);
        end
    endtask

    // ---------------- model: expand an accepted request into its cycle stream ----------------
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            exp_q.delete();
        end else if (start && !model_busy && length >= 4'd1 && int'(length) <= MAX_LEN) begin
            int reps;
            reps = (repeat_count == 4'd0) ? 1 : int'(repeat_count);
            for (int r = 1; r <= reps; r++) begin
                for (int i = int'(length) - 1; i >= 0; i--) begin
                    exp_q.push_back({1'b1, pattern[i], 1'b1, 1'b0});
                end
                if (r < reps) exp_q.push_back(4'b0010);
            end
            exp_q.push_back(4'b0011);
        end
    end

    // ---------------- compare + log ----------------
    always @(negedge clock) begin
        logic [3:0] e;
        if (reset)                  e = 4'b0000;
        else if (exp_q.size() > 0)  e = exp_q.pop_front();
        else                        e = 4'b0000;
        model_busy = e[1];
        check("cycle{valid,data,busy,done}", {60'd0, data_valid, data_out, busy, done}, {60'd0, e});
        if (data_valid) begin
            cap = {cap[62:0], data_out};
            cap_n++;
        end
        if (busy) busy_n++;
        if (done) done_n++;
    end

    // ---------------- driver tasks ----------------
    task automatic clear_log();
        cap    = '0;
        cap_n  = 0;
        busy_n = 0;
        done_n = 0;
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        check("idle_timeout", 64'(n >= budget), 64'd0);
        step();
    endtask

    task automatic run_req(input logic [7:0] pat, input logic [3:0] len, input logic [3:0] rep);
        step();
        clear_log();
        pattern      = pat;
        length       = len;
        repeat_count = rep;
        start        = 1'b1;
        step();
        start        = 1'b0;
        wait_idle(200);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        pattern      = '0;
        length       = 4'd0;
        repeat_count = 4'd0;
        clear_log();
        repeat (3) step();
        check("reset_outputs", {60'd0, data_valid, data_out, busy, done}, 64'd0);
        reset = 1'b0;
        step();

        // single transmission of 1100
        run_req(8'h0C, 4'd4, 4'd1);
        check("t1_bits", cap[3:0], 64'hC);
        check("t1_nbits", 64'(cap_n), 64'd4);
        check("t1_busy", 64'(busy_n), 64'd5);
        check("t1_done", 64'(done_n), 64'd1);

        // three repetitions with gaps
        run_req(8'h0C, 4'd4, 4'd3);
        check("t2_bits", cap[11:0], 64'hCCC);
        check("t2_nbits", 64'(cap_n), 64'd12);
        check("t2_busy", 64'(busy_n), 64'd15);
        check("t2_done", 64'(done_n), 64'd1);

        // illegal lengths are ignored
        run_req(8'hFF, 4'd0, 4'd1);
        check("len0_busy", 64'(busy_n), 64'd0);
        check("len0_valid", 64'(cap_n), 64'd0);
        run_req(8'hFF, 4'd9, 4'd1);
        check("len9_busy", 64'(busy_n), 64'd0);
        check("len9_valid", 64'(cap_n), 64'd0);

        // start re-asserted mid-transmission is ignored
        step();
        clear_log();
        pattern = 8'hA5; length = 4'd8; repeat_count = 4'd1; start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        pattern = 8'hFF; start = 1'b1;
        step();
        start = 1'b0;
        wait_idle(200);
        check("restart_bits", cap[7:0], 64'hA5);
        check("restart_nbits", 64'(cap_n), 64'd8);
        check("restart_done", 64'(done_n), 64'd1);

        // async reset during bit index 2, then fresh start on first edge after release
        step();
        clear_log();
        pattern = 8'hA5; length = 4'd8; repeat_count = 4'd1; start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("abort_outputs", {60'd0, data_valid, data_out, busy, done}, 64'd0);
        check("abort_prefix", cap[4:0], 64'h14);
        check("abort_nbits", 64'(cap_n), 64'd5);
        step();
        step();
        check("abort_no_done", 64'(done_n), 64'd0);
        clear_log();
        pattern = 8'h0C; length = 4'd4; repeat_count = 4'd2;
        reset = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_idle(200);
        check("post_reset_bits", cap[7:0], 64'hCC);
        check("post_reset_busy", 64'(busy_n), 64'd10);
        check("post_reset_done", 64'(done_n), 64'd1);

        // length 1, repeat 0 treated as 1
        run_req(8'h01, 4'd1, 4'd0);
        check("len1_bits", cap[0], 64'd1);
        check("len1_nbits", 64'(cap_n), 64'd1);
        check("len1_busy", 64'(busy_n), 64'd2);
        check("len1_done", 64'(done_n), 64'd1);

        // start held high: second request accepted in the IDLE cycle after DONE
        step();
        clear_log();
        pattern = 8'h81; length = 4'd8; repeat_count = 4'd1; start = 1'b1;
        repeat (11) step();
        start = 1'b0;
        wait_idle(200);
        check("b2b_bits", cap[15:0], 64'h8181);
        check("b2b_nbits", 64'(cap_n), 64'd16);
        check("b2b_busy", 64'(busy_n), 64'd18);
        check("b2b_done", 64'(done_n), 64'd2);

        // maximum repeat count
        run_req(8'h02, 4'd2, 4'd15);
        check("rep15_bits", cap[29:0], 64'h2AAAAAAA);
        check("rep15_nbits", 64'(cap_n), 64'd30);
        check("rep15_busy", 64'(busy_n), 64'd45);
        check("rep15_done", 64'(done_n), 64'd1);

        repeat (2) step();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
